// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and sizing helper for the sequential ALU.
package alu_pkg;

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_SHR = 5'b00101;
    localparam logic [4:0] OP_SRA = 5'b00110;
    localparam logic [4:0] OP_SHL = 5'b00111;
    localparam logic [4:0] OP_ROR = 5'b01000;
    localparam logic [4:0] OP_ROL = 5'b01001;
    localparam logic [4:0] OP_AND = 5'b01010;
    localparam logic [4:0] OP_OR  = 5'b01011;
    localparam logic [4:0] OP_MUL = 5'b01111;
    localparam logic [4:0] OP_DIV = 5'b10000;
    localparam logic [4:0] OP_NEG = 5'b10001;
    localparam logic [4:0] OP_NOT = 5'b10010;
    localparam logic [4:0] OP_INC = 5'b11111;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/iter_muldiv.sv
// One-iteration-per-cycle engine: radix-2 Booth multiply (mode 0) or
// unsigned restoring divide (mode 1). acc_o is the accumulator after this cycle's step.
module iter_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic               clock_i,
    input  logic               clear_i,
    input  logic               load_i,
    input  logic               mode_i,
    input  logic               step_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] acc_o
);

    // hi carries an extra bit so Booth add/sub of the most-negative multiplicand cannot overflow
    logic [WIDTH:0]   hi_q, hi_d, m_q, sum, shifted, diff;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             qm1_q, qm1_d, mode_q;

    always_comb begin
        hi_d    = hi_q;
        lo_d    = lo_q;
        qm1_d   = qm1_q;
        sum     = hi_q;
        shifted = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
        diff    = shifted - m_q;
        if (!mode_q) begin
            case ({lo_q[0], qm1_q})
                2'b01:   sum = hi_q + m_q;
                2'b10:   sum = hi_q - m_q;
                default: sum = hi_q;
            endcase
            {hi_d, lo_d, qm1_d} = {sum[WIDTH], sum, lo_q};
        end else if (diff[WIDTH]) begin
            hi_d = shifted;
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end else begin
            hi_d = diff;
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end
    end

    assign acc_o = {hi_d[WIDTH-1:0], lo_d};

    always_ff @(posedge clock_i) begin
        if (clear_i) begin
            hi_q   <= '0;
            lo_q   <= '0;
            qm1_q  <= 1'b0;
            m_q    <= '0;
            mode_q <= 1'b0;
        end else if (load_i) begin
            hi_q   <= '0;
            lo_q   <= a_i;
            qm1_q  <= 1'b0;
            m_q    <= mode_i ? {1'b0, b_i} : {b_i[WIDTH-1], b_i};
            mode_q <= mode_i;
        end else if (step_i) begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            qm1_q  <= qm1_d;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle ops finish in one clock, MUL/DIV iterate WIDTH clocks.
// state | meaning: IDLE wait for start | RUN mul/div iterating | FIN done pulse, start accepted
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = 5
) (
    input  logic               clock_i,
    input  logic               clear_i,
    input  logic               start_i,
    input  logic [OPW-1:0]     control_i,
    input  logic [WIDTH-1:0]   y_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] result_o,
    output logic               div_by_zero_o
);

    localparam int CW = clog2(WIDTH);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic [OPW-1:0]     op_q, op_d;
    logic               dbz_q, dbz_d, y_sign_q, y_sign_d, b_sign_q, b_sign_d;

    logic               is_mul, is_div, b_zero, md_load;
    logic [CW-1:0]      shamt;
    logic [WIDTH-1:0]   y_mag, b_mag, alu_lo, quo, rem;
    logic [2*WIDTH-1:0] md_acc;

    assign is_mul  = (control_i == OP_MUL);
    assign is_div  = (control_i == OP_DIV);
    assign b_zero  = (b_i == '0);
    assign md_load = start_i && (state_q != RUN) && (is_mul || (is_div && !b_zero));
    assign shamt   = b_i[CW-1:0];
    assign y_mag   = y_i[WIDTH-1] ? -y_i : y_i;
    assign b_mag   = b_i[WIDTH-1] ? -b_i : b_i;

    iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clock_i (clock_i),
        .clear_i (clear_i),
        .load_i  (md_load),
        .mode_i  (is_div),
        .step_i  (state_q == RUN),
        .a_i     (is_div ? y_mag : y_i),
        .b_i     (is_div ? b_mag : b_i),
        .acc_o   (md_acc)
    );

    always_comb begin
        alu_lo = y_i | b_i;
        case (control_i)
            OP_ADD: alu_lo = y_i + b_i;
            OP_SUB: alu_lo = y_i - b_i;
            OP_SHR: alu_lo = y_i >> shamt;
            OP_SRA: alu_lo = $signed(y_i) >>> shamt;
            OP_SHL: alu_lo = y_i << shamt;
            OP_ROR: alu_lo = (y_i >> shamt) | (y_i << (WIDTH - int'(shamt)));
            OP_ROL: alu_lo = (y_i << shamt) | (y_i >> (WIDTH - int'(shamt)));
            OP_AND: alu_lo = y_i & b_i;
            OP_NEG: alu_lo = -y_i;
            OP_NOT: alu_lo = ~y_i;
            OP_INC: alu_lo = y_i + WIDTH'(1);
            default: alu_lo = y_i | b_i;
        endcase
    end

    // Magnitude divide result gets its signs back on the way into result_q
    assign quo = (y_sign_q ^ b_sign_q) ? -md_acc[WIDTH-1:0] : md_acc[WIDTH-1:0];
    assign rem = y_sign_q ? -md_acc[2*WIDTH-1:WIDTH] : md_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        op_d     = op_q;
        dbz_d    = dbz_q;
        y_sign_d = y_sign_q;
        b_sign_d = b_sign_q;
        case (state_q)
            IDLE, FIN: begin
                state_d = IDLE;
                if (start_i) begin
                    op_d     = control_i;
                    y_sign_d = y_i[WIDTH-1];
                    b_sign_d = b_i[WIDTH-1];
                    dbz_d    = 1'b0;
                    state_d  = FIN;
                    if (is_mul || (is_div && !b_zero)) begin
                        state_d = RUN;
                        cnt_d   = CW'(WIDTH - 1);
                    end else if (is_div) begin
                        result_d = {y_i, {WIDTH{1'b1}}};
                        dbz_d    = 1'b1;
                    end else begin
                        result_d = {{WIDTH{1'b0}}, alu_lo};
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d  = FIN;
                    result_d = (op_q == OP_DIV) ? {rem, quo} : md_acc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (clear_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            op_q     <= '0;
            dbz_q    <= 1'b0;
            y_sign_q <= 1'b0;
            b_sign_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            op_q     <= op_d;
            dbz_q    <= dbz_d;
            y_sign_q <= y_sign_d;
            b_sign_q <= b_sign_d;
        end
    end

    assign busy_o        = (state_q == RUN);
    assign done_o        = (state_q == FIN);
    assign result_o      = result_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, multi-cycle successor to the datapath ALU.
- Single-cycle ops (logic, shift, rotate, add/sub, neg, not, inc) complete in 1 cycle.
- MUL (radix-2 Booth) and DIV (signed restoring) run iteratively over WIDTH cycles.
- Operands are captured on a start/done handshake, so the control unit can stall on busy instead of waiting out a long combinational path.
- Sits between the Y/B operand sources and the Z (HI/LO) result register.

Parameters:
WIDTH, 32, operand width in bits (power of two, >= 8)
OPW, 5, opcode width; fixed encoding, see Behaviour

Ports:
clock  in  1  rising-edge clock
clear  in  1  synchronous, active-high reset
start  in  1  begin op; sampled only when busy=0
control  in  OPW  opcode, captured with start
y  in  WIDTH  operand A (temp register), captured with start
b  in  WIDTH  operand B / shift count, captured with start
busy  out  1  high from cycle after accepted start until done
done  out  1  one-cycle pulse; result valid from that cycle
result  out  2*WIDTH  registered result; upper half = HI, lower = LO
div_by_zero  out  1  set with done for DIV with b=0; cleared on next accepted start

Behaviour:
- Clock and reset: one clock, clock. clear is a synchronous, active-high reset.
- Reset state (clear=1 at a clock edge): state=IDLE, busy=0, done=0, result=0, div_by_zero=0, all internal iteration registers 0.
  - clear overrides start in the same cycle.
  - clear mid-operation aborts the op; no done pulse is issued.
- FSM states: IDLE, RUN, FIN.
  - IDLE + start: latch control/y/b.
    - Single-cycle op: result written, FIN entered.
    - MUL/DIV: RUN entered with counter=WIDTH-1.
  - RUN: one iteration per cycle; counter==0 -> FIN.
  - FIN: done=1 for exactly one cycle, busy=0, return to IDLE.
    - start is accepted in FIN, giving back-to-back ops.
- start while busy=1 is ignored; the in-flight operation is not disturbed.
- Latency, start cycle to done cycle: single-cycle ops 1; MUL WIDTH+1; DIV WIDTH+1; DIV with b=0 is 1.
- result holds its value until the next completion or clear.
- Opcodes (binary):
  - 00011 ADD, 00100 SUB (y-b), 00101 SHR, 00110 SRA, 00111 SHL, 01000 ROR, 01001 ROL
  - 01010 AND, 01011 OR, 01111 MUL, 10000 DIV, 10001 NEG (-y), 10010 NOT (~y), 11111 INC (y+1)
  - Any other code executes OR.
- Width rules, single-cycle ops:
  - Result is WIDTH bits, zero-extended into the upper half.
  - ADD/SUB/INC wrap modulo 2^WIDTH; carry is discarded.
- Shifts and rotates: count = b[clog2(WIDTH)-1:0]; upper bits of b are ignored, count 0 returns y.
- MUL: signed y*b, full 2*WIDTH signed product.
  - Booth: examine {Q0,Q-1}; add/sub multiplicand into the upper half; arithmetic-shift right 1 per iteration.
- DIV, signed:
  - LO = quotient, truncated toward zero.
  - HI = remainder, with the sign of the dividend y.
  - Magnitudes are divided by restoring shift-subtract; signs are fixed up in the FIN transition.
  - Most-negative / -1: LO = most-negative value (wraps), HI = 0.
  - b=0: no iterations; result={y, all-ones}, div_by_zero=1 with done.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams (OP_ADD ... OP_INC);
  - FSM state enum {IDLE, RUN, FIN};
  - a clog2 helper function.
- The single-cycle op mux stays in seq_alu.
- One natural sub-module: iter_muldiv (WIDTH param). It takes load/mode/a/b, steps one iteration per cycle, and outputs a 2*WIDTH accumulator.
- seq_alu owns the FSM, counter, sign fix-up and the div_by_zero path.

Test Plan:
- Reset and single-cycle ops: clear, then start ADD y=32'hFFFFFFFF b=1.
  - Cycle 1: done=1, result=64'h0.
  - Next op, ROL y=32'h80000001 b=33: result=64'h0000_0000_0000_0003 (count 1).
- MUL: start MUL y=7 b=-3 (32'hFFFFFFFD).
  - busy high 32 cycles; done on cycle 33; result=64'hFFFF_FFFF_FFFF_FFEB.
- DIV signed: y=-7 b=2 -> done on cycle 33, result={32'hFFFFFFFF, 32'hFFFFFFFD}.
  - Then y=100 b=7 -> result={32'd2, 32'd14}.
- Divide by zero: DIV y=32'h1234 b=0 -> done on cycle 1, div_by_zero=1, result={32'h1234, 32'hFFFFFFFF}.
  - Next start ADD clears div_by_zero.
- Hazards:
  - During MUL (cycle 5), pulse start with ADD: ignored; MUL result unchanged.
  - Assert clear at cycle 10 of a second MUL: next cycle busy=0, result=0, no done pulse ever.
  - Unknown opcode 00000, y=4'hA b=4'h5: result=64'hF.
